// File: rtl/mux41_arb_pkg.sv
// rtl/mux41_arb_pkg.sv - shared constants, state encoding and helpers for mux41_arbiter
package mux41_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] SEL_A = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C = 2'd2;
    localparam logic [SEL_W-1:0] SEL_D = 2'd3;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux41_arbiter_rr_pick4.sv
// rtl/mux41_arbiter_rr_pick4.sv - combinational round-robin pick of the first request at or after ptr
module rr_pick4
    import mux41_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (req[idx] && !any) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_arbiter.sv
// rtl/mux41_arbiter.sv - round-robin break-before-make arbiter driving a registered 4:1 mux
// Optional grant timeout enabled by defining MUX41_ARB_TIMEOUT_EN.
module mux41_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [3:0]       Req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       Gnt,
    output logic             Gnt_valid,
    output logic [1:0]       Sel,
    output logic [WIDTH-1:0] Mux_out
);
    import mux41_arb_pkg::*;

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("mux41_arbiter: MAX_HOLD out of range 2..256");
    end

    state_t             state, state_d;
    logic [SEL_W-1:0]   ptr, ptr_d, sel_d, winner;
    logic [NUM_REQ-1:0] gnt_d;
    logic               gnt_valid_d, any, hold_expired;
    logic [WIDTH-1:0]   mux_sel, mux_d;

    rr_pick4 u_pick (
        .req    (Req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

`ifdef MUX41_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt;

    // Zero in every non-GRANT cycle, so the first GRANT cycle always sees 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            hold_cnt <= '0;
        else if (state != GRANT)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (any) state_d = GRANT;
            GRANT:   if (!Req[Sel] || hold_expired) state_d = RELEASE;
            RELEASE: state_d = any ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant outputs only change on GRANT entry/exit; Sel keeps the last owner.
    always_comb begin
        gnt_d       = Gnt;
        gnt_valid_d = Gnt_valid;
        sel_d       = Sel;
        ptr_d       = ptr;
        if (state != GRANT && state_d == GRANT) begin
            gnt_d       = onehot(winner);
            gnt_valid_d = 1'b1;
            sel_d       = winner;
            ptr_d       = winner + SEL_W'(1);
        end else if (state == GRANT && state_d != GRANT) begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
        end
    end

    always_comb begin
        mux_sel = '0;
        case (Sel)
            SEL_A:   mux_sel = A;
            SEL_B:   mux_sel = B;
            SEL_C:   mux_sel = C;
            SEL_D:   mux_sel = D;
            default: mux_sel = '0;
        endcase
        mux_d = Gnt_valid ? mux_sel : '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Gnt       <= '0;
            Gnt_valid <= 1'b0;
            Sel       <= SEL_A;
            ptr       <= SEL_A;
            Mux_out   <= '0;
        end else begin
            Gnt       <= gnt_d;
            Gnt_valid <= gnt_valid_d;
            Sel       <= sel_d;
            ptr       <= ptr_d;
            Mux_out   <= mux_d;
        end
    end

endmodule
